// File: rtl/pipe_pkg.sv
// Shared types and default widths for the flushable pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } stage_state_t;

  localparam int PIPE_DATA_W      = 96;
  localparam int PIPE_CTRL_W      = 8;
  localparam int PIPE_STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload+ctrl register; clear kills the entry but leaves the payload in place.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Clear wins over load so an entry accepted during a flush is dropped.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d_data;
      ctrl_d  = d_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flushable valid/ready pipeline-stage register with optional skid buffer and stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = PIPE_DATA_W,
  parameter int CTRL_W      = PIPE_CTRL_W,
  parameter bit SKID        = 1'b1,
  parameter int STALL_CNT_W = PIPE_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("pipe_stage_reg: DATA_W must be at least 1");
  end
  if (CTRL_W < 1) begin : g_bad_ctrl_w
    $error("pipe_stage_reg: CTRL_W must be at least 1");
  end
  if (STALL_CNT_W < 1) begin : g_bad_stall_w
    $error("pipe_stage_reg: STALL_CNT_W must be at least 1");
  end

  logic              accept, drain;
  logic              main_valid, main_load, main_clear;
  logic [DATA_W-1:0] main_data, main_d_data;
  logic [CTRL_W-1:0] main_ctrl, main_d_ctrl;

  assign accept     = in_valid & in_ready;
  assign drain      = main_valid & out_ready;
  assign main_clear = flush | (drain & ~main_load);

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (main_valid),
    .data   (main_data),
    .ctrl   (main_ctrl)
  );

  if (SKID) begin : g_skid
    stage_state_t      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              skid_load, skid_clear, skid_valid, sel_skid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_data (in_data),
      .d_ctrl (in_ctrl),
      .valid  (skid_valid),
      .data   (skid_data),
      .ctrl   (skid_ctrl)
    );

    always_comb begin
      state_d    = state_q;
      main_load  = 1'b0;
      sel_skid   = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
        state_d    = ST_EMPTY;
        skid_clear = 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              main_load = 1'b1;
              state_d   = ST_FULL;
            end
          end
          ST_FULL: begin
            if (accept && drain) begin
              main_load = 1'b1;
            end else if (accept) begin
              skid_load = 1'b1;
              state_d   = ST_SKID;
            end else if (drain) begin
              state_d = ST_EMPTY;
            end
          end
          ST_SKID: begin
            if (drain && skid_valid) begin
              main_load  = 1'b1;
              sel_skid   = 1'b1;
              skid_clear = 1'b1;
              state_d    = ST_FULL;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
      in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q    <= ST_EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        in_ready_q <= in_ready_d;
      end
    end

    assign in_ready    = in_ready_q;
    assign main_d_data = sel_skid ? skid_data : in_data;
    assign main_d_ctrl = sel_skid ? skid_ctrl : in_ctrl;
  end else begin : g_noskid
    assign in_ready    = out_ready | ~main_valid;
    assign main_load   = accept & ~flush;
    assign main_d_data = in_data;
    assign main_d_ctrl = in_ctrl;
  end

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; flush deliberately leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid, saturating-counter and combinational-ready variants share one stimulus bus.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [95:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_ready;

  logic        s_in_ready, s_out_valid;
  logic [95:0] s_out_data;
  logic [7:0]  s_out_ctrl;
  logic [15:0] s_stall;

  logic        t_in_ready, t_out_valid;
  logic [95:0] t_out_data;
  logic [7:0]  t_out_ctrl;
  logic [3:0]  t_stall;

  logic        c_in_ready, c_out_valid;
  logic [95:0] c_out_data;
  logic [7:0]  c_out_ctrl;
  logic [15:0] c_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1'b1), .STALL_CNT_W(16)) dut_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .stall_cnt(s_stall)
  );

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1'b1), .STALL_CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(t_out_valid), .out_ready(out_ready),
    .out_data(t_out_data), .out_ctrl(t_out_ctrl), .stall_cnt(t_stall)
  );

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1'b0), .STALL_CNT_W(16)) dut_comb (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_ctrl(c_out_ctrl), .stall_cnt(c_stall)
  );

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [7:0]  exp_ctrl;
    logic        exp_in_ready;
    logic [15:0] exp_stall;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic [7:0] c,
                              input logic ordy, input logic fl, input logic ev,
                              input logic [31:0] ed, input logic [7:0] ec, input logic erdy,
                              input logic [15:0] es, input logic cd);
    vec_t v;
    v.in_valid = iv;   v.in_data = d;   v.in_ctrl = c;   v.out_ready = ordy; v.flush = fl;
    v.exp_valid = ev;  v.exp_data = ed; v.exp_ctrl = ec; v.exp_in_ready = erdy;
    v.exp_stall = es;  v.chk_data = cd;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply_stimulus(input int i, input vec_t v);
    @(negedge clk);
    in_valid  = v.in_valid;
    in_data   = {64'h0, v.in_data};
    in_ctrl   = v.in_ctrl;
    out_ready = v.out_ready;
    flush     = v.flush;
    @(posedge clk);
    #1;
    check_output($sformatf("v%0d out_valid", i), {127'h0, s_out_valid}, {127'h0, v.exp_valid});
    if (v.chk_data)
      check_output($sformatf("v%0d out_data", i), {32'h0, s_out_data}, {96'h0, v.exp_data});
    check_output($sformatf("v%0d out_ctrl", i), {120'h0, s_out_ctrl}, {120'h0, v.exp_ctrl});
    check_output($sformatf("v%0d in_ready", i), {127'h0, s_in_ready}, {127'h0, v.exp_in_ready});
    check_output($sformatf("v%0d stall_cnt", i), {112'h0, s_stall}, {112'h0, v.exp_stall});
  endtask

  task automatic comb_step(input logic iv, input logic [31:0] d, input logic ordy,
                           input logic exp_rdy, input logic exp_v, input logic [31:0] exp_d);
    @(negedge clk);
    in_valid = iv; in_data = {64'h0, d}; in_ctrl = 8'h01; out_ready = ordy; flush = 1'b0;
    #1;
    check_output("comb in_ready", {127'h0, c_in_ready}, {127'h0, exp_rdy});
    @(posedge clk);
    #1;
    check_output("comb out_valid", {127'h0, c_out_valid}, {127'h0, exp_v});
    check_output("comb out_data", {32'h0, c_out_data}, {96'h0, exp_d});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;

    // Streaming, backpressure into the skid entry, then flush corner cases.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1, i, 8'h01, 1, 0,  1, i, 8'h01, 1, 16'd0, 1));
    vecs.push_back(mk(0, 0,     8'h00, 1, 0,  0, 8,     8'h00, 1, 16'd0, 1));
    vecs.push_back(mk(1, 'hA,   8'h02, 0, 0,  1, 'hA,   8'h02, 1, 16'd0, 1));
    vecs.push_back(mk(1, 'hB,   8'h03, 0, 0,  1, 'hA,   8'h02, 0, 16'd1, 1));
    vecs.push_back(mk(1, 'hC,   8'h04, 0, 0,  1, 'hA,   8'h02, 0, 16'd2, 1));
    vecs.push_back(mk(1, 'hC,   8'h04, 0, 0,  1, 'hA,   8'h02, 0, 16'd3, 1));
    vecs.push_back(mk(1, 'hC,   8'h04, 1, 0,  1, 'hB,   8'h03, 1, 16'd3, 1));
    vecs.push_back(mk(1, 'hC,   8'h04, 1, 0,  1, 'hC,   8'h04, 1, 16'd3, 1));
    vecs.push_back(mk(0, 0,     8'h00, 1, 0,  0, 'hC,   8'h00, 1, 16'd3, 1));
    vecs.push_back(mk(1, 'hD,   8'h05, 0, 0,  1, 'hD,   8'h05, 1, 16'd3, 1));
    vecs.push_back(mk(1, 'hE,   8'h06, 0, 0,  1, 'hD,   8'h05, 0, 16'd4, 1));
    vecs.push_back(mk(1, 'hF,   8'hFF, 0, 1,  0, 'hD,   8'h00, 1, 16'd5, 1));
    vecs.push_back(mk(0, 0,     8'h00, 1, 0,  0, 'hD,   8'h00, 1, 16'd5, 1));
    vecs.push_back(mk(1, 'h10,  8'h07, 1, 1,  0, 'hD,   8'h00, 1, 16'd5, 0));
    vecs.push_back(mk(0, 0,     8'h00, 1, 0,  0, 'hD,   8'h00, 1, 16'd5, 0));
    vecs.push_back(mk(1, 'h11,  8'h08, 0, 0,  1, 'h11,  8'h08, 1, 16'd5, 1));
    vecs.push_back(mk(0, 0,     8'h00, 1, 1,  0, 'h11,  8'h00, 1, 16'd5, 1));
    vecs.push_back(mk(1, 'h12,  8'h09, 1, 0,  1, 'h12,  8'h09, 1, 16'd5, 1));

    #1;
    check_output("reset out_valid", {127'h0, s_out_valid}, 128'h0);
    check_output("reset out_data", {32'h0, s_out_data}, 128'h0);
    check_output("reset out_ctrl", {120'h0, s_out_ctrl}, 128'h0);
    check_output("reset stall_cnt", {112'h0, s_stall}, 128'h0);
    #6 reset = 1'b0;
    #1;
    check_output("idle skid in_ready", {127'h0, s_in_ready}, 128'h1);
    check_output("idle comb in_ready", {127'h0, c_in_ready}, 128'h1);

    foreach (vecs[i]) apply_stimulus(i, vecs[i]);

    // Asynchronous reset while an entry sits in the skid slot.
    do_reset();
    @(negedge clk); in_valid = 1'b1; in_data = 96'h40; in_ctrl = 8'h11; out_ready = 1'b0;
    @(negedge clk); in_data = 96'h41;
    @(posedge clk); #2;
    check_output("pre-reset out_valid", {127'h0, s_out_valid}, 128'h1);
    check_output("pre-reset in_ready", {127'h0, s_in_ready}, 128'h0);
    reset = 1'b1;
    #1;
    check_output("async out_valid", {127'h0, s_out_valid}, 128'h0);
    check_output("async out_data", {32'h0, s_out_data}, 128'h0);
    check_output("async out_ctrl", {120'h0, s_out_ctrl}, 128'h0);
    check_output("async stall_cnt", {112'h0, s_stall}, 128'h0);
    check_output("async in_ready", {127'h0, s_in_ready}, 128'h1);
    @(negedge clk); reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("post-reset no stale entry", {127'h0, s_out_valid}, 128'h0);

    // Stall saturation on the 4-bit counter.
    do_reset();
    @(negedge clk); in_valid = 1'b1; in_data = 96'h20; in_ctrl = 8'h01; out_ready = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 10) check_output("sat stall@10", {124'h0, t_stall}, 128'd9);
      if (cyc == 16) check_output("sat stall@16", {124'h0, t_stall}, 128'd15);
      if (cyc == 20) check_output("sat stall@20", {124'h0, t_stall}, 128'd15);
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check_output("sat flush out_valid", {127'h0, t_out_valid}, 128'h0);
    check_output("sat flush stall", {124'h0, t_stall}, 128'd15);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check_output("sat hold stall", {124'h0, t_stall}, 128'd15);

    // Combinational-ready variant with out_ready toggling.
    do_reset();
    comb_step(1, 32'h31, 1, 1, 1, 32'h31);
    @(negedge clk); in_valid = 1'b1; in_data = 96'h32; out_ready = 1'b0;
    #1; check_output("comb rdy low", {127'h0, c_in_ready}, 128'h0);
    out_ready = 1'b1;
    #1; check_output("comb rdy follows", {127'h0, c_in_ready}, 128'h1);
    out_ready = 1'b0;
    #1; check_output("comb rdy drops", {127'h0, c_in_ready}, 128'h0);
    @(posedge clk); #1;
    check_output("comb hold data", {32'h0, c_out_data}, 128'h31);
    comb_step(1, 32'h32, 1, 1, 1, 32'h32);
    comb_step(1, 32'h33, 0, 0, 1, 32'h32);
    comb_step(1, 32'h33, 1, 1, 1, 32'h33);
    comb_step(0, 32'h0,  1, 1, 0, 32'h33);
    check_output("comb bubble ctrl", {120'h0, c_out_ctrl}, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, flushable pipeline-stage register with valid/ready handshake. It is the successor to the fixed-field inter-stage registers and sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
It carries an opaque payload plus a control bundle. The control bundle is forced to zero whenever the stage holds a bubble. Optional skid-buffer mode cuts the ready path, and a saturating stall counter supports performance analysis.

Parameters:
DATA_W, 96, width of payload bus (results, operands, PCs); never cleared except by reset
CTRL_W, 8, width of control bundle (reg_write, mem_read, mem_write, jal, ...); zeroed whenever out_valid=0
SKID, 1, 0 = single register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all held and incoming entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bundle
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  registered payload
out_ctrl  output  CTRL_W  registered control; 0 when out_valid=0
stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clock and reset: clk is the clock. reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0; skid entry invalid. in_ready is 1 for SKID=1 and also evaluates to 1 for SKID=0.
- Handshakes: accept = in_valid & in_ready; drain = out_valid & out_ready. No entry is lost, duplicated or reordered.
- Latency: an accepted entry appears on out_* on the next cycle.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On accept, the main register loads in_data/in_ctrl and out_valid<=1.
  - On drain without accept, out_valid<=0.
- SKID=1 uses states EMPTY (main invalid), FULL (main valid, skid invalid) and SKID (both valid). in_ready = (state != SKID) and is registered, with no combinational path from out_ready.
  - EMPTY: accept -> FULL, main loads input.
  - FULL:
    - accept & drain -> FULL, main loads input.
    - accept & ~drain -> SKID, skid loads input.
    - drain & ~accept -> EMPTY.
  - SKID: drain -> FULL, main loads skid contents. No accept is possible in this state.
- flush (highest priority below reset):
  - Next cycle: out_valid=0, skid invalid, state EMPTY, in_ready=1.
  - An entry accepted in the flush cycle is discarded.
  - A drain in the flush cycle still counts as delivered downstream.
- out_ctrl: equals the stored ctrl when out_valid=1, else all zeros, so a bubble can never raise reg_write or mem_write. out_data keeps its last value on a bubble.
- stall_cnt:
  - Increments when out_valid & ~out_ready, and holds at 2^STALL_CNT_W-1.
  - Not cleared by flush; only reset clears it.
- Async reset mid-transfer: all entries are dropped immediately, including any skid entry.
- Widths: DATA_W ≥ 1, CTRL_W ≥ 1, STALL_CNT_W ≥ 1, checked by elaboration assertions.

Decomposition:
- Package pipe_pkg holds:
  - the enum stage_state_t {ST_EMPTY, ST_FULL, ST_SKID};
  - default width constants (PIPE_STALL_CNT_W=16).
- Sub-module pipe_slot: one valid+payload+ctrl register with load and clear enables. It is instantiated once as main, plus once as skid when SKID=1.
- The top level holds the FSM, the ctrl-masking output and the stall counter.

Test Plan:
1. Reset then idle:
   - Assert reset mid-cycle -> out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0 asynchronously.
   - in_ready=1 after release.
2. Streaming, out_ready=1:
   - Push data 0x1..0x8, ctrl 0x01, one per cycle -> each appears one cycle later, in order.
   - in_ready stays 1 and stall_cnt stays 0.
3. Backpressure, SKID=1:
   - Push A, B, C with out_ready=0 -> A held on out, B captured in skid, in_ready=0 after B, C not accepted.
   - Raise out_ready -> A, B, C drain in order.
   - stall_cnt equals the count of cycles with out_ready low while out_valid=1.
4. Flush with full skid:
   - State SKID plus in_valid with ctrl=0xFF and flush=1 -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1.
   - No flushed entry ever appears.
5. Stall saturation, STALL_CNT_W=4:
   - Hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
   - A following flush leaves it at 15.
6. SKID=0 variant:
   - out_ready toggling 1,0,1 while pushing -> in_ready follows out_ready combinationally in the same cycle.
   - Zero data loss, latency 1.
